// File: rtl/control_pkg.sv
// Shared typedefs for the accumulator CPU: instruction opcodes, sequencer
// states and the opcode-class helper used by the control sequencer.
package control_pkg;

    // Opcodes are four bits wide so values 8..15 exist on the bus but are undefined.
    typedef enum logic [3:0] {
        HLT = 4'd0,
        SKZ = 4'd1,
        ADD = 4'd2,
        AND = 4'd3,
        XOR = 4'd4,
        LDA = 4'd5,
        STO = 4'd6,
        JMP = 4'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    function automatic logic isAluOp(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/control.sv
// Eight-phase instruction sequencer: steps through fetch/execute phases and
// decodes the datapath control strobes from the phase, opcode and zero flag.
module control
    import control_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    load_ir,
    output logic    load_ac,
    output logic    inc_pc,
    output logic    load_pc,
    output logic    halt,
    output state_t  phase
);

    state_t state_q, state_d;
    logic   halted_q, halted_d;
    logic   isAlu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        isAlu    = isAluOp(opcode);
        state_d  = state_t'(state_q + 3'd1);
        halted_d = halted_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        load_ir  = 1'b0;
        load_ac  = 1'b0;
        inc_pc   = 1'b0;
        load_pc  = 1'b0;
        halt     = 1'b0;

        // A halt freezes the sequencer in OP_ADDR on the same edge that latches it.
        if (halted_q) begin
            state_d = state_q;
            halt    = 1'b1;
        end else begin
            case (state_q)
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    if (opcode == HLT) begin
                        halt     = 1'b1;
                        halted_d = 1'b1;
                        state_d  = state_q;
                    end
                end
                OP_FETCH: mem_rd = isAlu;
                ALU_OP: begin
                    mem_rd  = isAlu;
                    load_ac = isAlu;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                end
                STORE: begin
                    mem_rd  = isAlu;
                    load_ac = isAlu;
                    mem_wr  = (opcode == STO);
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                end
                default: ;
            endcase
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the control sequencer: directed instruction runs
// followed by randomized opcodes, zero flags and resets against a step model.
module tb_control;
    import control_pkg::*;

    logic    clk;
    logic    rst;
    opcode_t opcode;
    logic    zero;
    logic    mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
    state_t  phase;

    int checkCount = 0;
    int errorCount = 0;

    int modelStep   = 0;
    bit modelHalted = 1'b0;
    bit modelValid  = 1'b0;

    control dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .inc_pc  (inc_pc),
        .load_pc (load_pc),
        .halt    (halt),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b expected %b (step %0d halted %0d)",
                     tag, actual, expected, modelStep, modelHalted);
        end
    endtask

    // Expected strobes packed as {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}.
    function automatic logic [7:0] expectedStrobes(input int step, input bit halted, input int op, input bit z);
        bit rd = 0, wr = 0, ir = 0, ac = 0, inc = 0, pc = 0, hl = 0;
        bit aluClass = (op == int'(ADD)) || (op == int'(AND)) || (op == int'(XOR)) || (op == int'(LDA));
        if (halted) begin
            hl = 1;
        end else if (step == 1) begin
            rd = 1;
        end else if (step == 2 || step == 3) begin
            rd = 1; ir = 1;
        end else if (step == 4) begin
            inc = 1; hl = (op == int'(HLT));
        end else if (step == 5) begin
            rd = aluClass;
        end else if (step == 6) begin
            rd = aluClass; ac = aluClass;
            inc = (op == int'(SKZ)) && z;
            pc = (op == int'(JMP));
        end else if (step == 7) begin
            rd = aluClass; ac = aluClass;
            wr = (op == int'(STO));
            inc = (op == int'(JMP)); pc = (op == int'(JMP));
        end
        return {1'b0, rd, wr, ir, ac, inc, pc, hl};
    endfunction

    // Drive one cycle's inputs, check outputs mid-cycle, then advance the model on the edge.
    task automatic applyStimulus(input bit r, input int op, input bit z);
        rst    = r;
        opcode = opcode_t'(op[3:0]);
        zero   = z;
        #1;
        if (modelValid) begin
            checkOutput("strobes", {1'b0, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt},
                        expectedStrobes(modelStep, modelHalted, op, z));
            checkOutput("phase", {5'b0, phase}, 8'(modelStep));
            checkOutput("rd_wr_excl", {7'b0, mem_rd & mem_wr}, 8'd0);
            checkOutput("pc_ac_excl", {7'b0, load_pc & load_ac}, 8'd0);
        end
        @(posedge clk);
        if (r) begin
            modelStep   = 0;
            modelHalted = 0;
            modelValid  = 1;
        end else if (!modelHalted) begin
            if (modelStep == 4 && op == int'(HLT)) modelHalted = 1;
            else modelStep = (modelStep + 1) % 8;
        end
        @(negedge clk);
    endtask

    // Run n cycles of one opcode; zero is random except in ALU_OP when zForce is 0 or 1.
    task automatic runOp(input int op, input int n, input int zForce);
        for (int i = 0; i < n; i++) begin
            bit z = 1'($urandom_range(0, 1));
            if (modelStep == 6 && zForce >= 0) z = zForce[0];
            applyStimulus(1'b0, op, z);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = ADD; zero = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, int'(ADD), 1'b0);
        applyStimulus(1'b1, int'(ADD), 1'b0);

        runOp(int'(ADD), 9, -1);
        runOp(int'(SKZ), 7, 1);
        runOp(int'(SKZ), 8, 0);
        runOp(int'(JMP), 8, -1);
        runOp(int'(STO), 8, -1);
        runOp(int'(LDA), 8, -1);
        runOp(int'(XOR), 8, -1);
        runOp(int'(11), 8, -1);

        runOp(int'(HLT), 5, -1);
        runOp(int'(HLT), 20, -1);
        runOp(int'(ADD), 3, -1);
        applyStimulus(1'b1, int'(ADD), 1'b0);

        runOp(int'(STO), 5, -1);
        applyStimulus(1'b1, int'(STO), 1'b0);
        runOp(int'(STO), 10, -1);

        for (int i = 0; i < 600; i++) begin
            bit r = ($urandom_range(0, 39) == 0);
            int op = (i / 8) % 2 == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 7));
            applyStimulus(r, op, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
